// File: rtl/dmem_access_ctrl.sv
// MEM-stage data-memory access sequencer: drives a req/ack bus, formats store lanes,
// aligns/extends load data and stalls the pipeline until the access resolves.
module dmem_access_ctrl #(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        mwmem,
   input  logic        mm2reg,
   input  logic [2:0]  mfunc3,
   input  logic [63:0] mr,
   input  logic [63:0] mqb,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [63:0] dmem_addr,
   output logic [63:0] dmem_wdata,
   output logic [7:0]  dmem_wstrb,
   input  logic        dmem_ack,
   input  logic [63:0] dmem_rdata,
   output logic        mem_stall,
   output logic [63:0] mdata,
   output logic        mdone,
   output logic        mfault,
   output logic        mbuserr
);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

   localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

   state_t      state_q;
   logic        req_q, we_q, store_q;
   logic [63:0] addr_q, wdata_q, mdata_q;
   logic [7:0]  wstrb_q, cnt_q;
   logic        mdone_q, mfault_q, mbuserr_q;
   logic [2:0]  off_q, func3_q;

   logic        access, is_store, illegal, misaligned, fault, start;
   logic [7:0]  size_mask;
   logic [2:0]  align_mask;
   logic [7:0]  wstrb_d;
   logic [63:0] wdata_d, shifted, ldata_d;

   always_comb begin
      access   = mwmem | mm2reg;
      is_store = mwmem;
      size_mask  = 8'h01;
      align_mask = 3'b000;
      case (mfunc3[1:0])
         2'b00: begin size_mask = 8'h01; align_mask = 3'b000; end
         2'b01: begin size_mask = 8'h03; align_mask = 3'b001; end
         2'b10: begin size_mask = 8'h0F; align_mask = 3'b011; end
         default: begin size_mask = 8'hFF; align_mask = 3'b111; end
      endcase
      illegal    = (mfunc3 == 3'b111) |
                   (is_store & (mfunc3[2] | (mfunc3[1:0] == 2'b11)));
      misaligned = |(mr[2:0] & align_mask);
      fault      = access & (illegal | misaligned);
      start      = access & ~fault;
      wstrb_d    = size_mask << mr[2:0];
      wdata_d    = mqb << {mr[2:0], 3'b000};
   end

   // Load alignment uses the offset/func3 latched at request time.
   always_comb begin
      shifted = dmem_rdata >> {off_q, 3'b000};
      ldata_d = shifted;
      case (func3_q)
         3'b000:  ldata_d = {{56{shifted[7]}},  shifted[7:0]};
         3'b001:  ldata_d = {{48{shifted[15]}}, shifted[15:0]};
         3'b010:  ldata_d = {{32{shifted[31]}}, shifted[31:0]};
         3'b100:  ldata_d = {56'd0, shifted[7:0]};
         3'b101:  ldata_d = {48'd0, shifted[15:0]};
         3'b110:  ldata_d = {32'd0, shifted[31:0]};
         default: ldata_d = shifted;
      endcase
   end

   assign mem_stall = resetn & (((state_q == S_IDLE) & start) | (state_q == S_WAIT));

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q   <= S_IDLE;
         req_q     <= 1'b0;
         we_q      <= 1'b0;
         store_q   <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         wstrb_q   <= '0;
         mdata_q   <= '0;
         mdone_q   <= 1'b0;
         mfault_q  <= 1'b0;
         mbuserr_q <= 1'b0;
         cnt_q     <= '0;
         off_q     <= '0;
         func3_q   <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               mdone_q   <= 1'b0;
               mbuserr_q <= 1'b0;
               mfault_q  <= fault;
               if (start) begin
                  req_q   <= 1'b1;
                  we_q    <= is_store;
                  store_q <= is_store;
                  addr_q  <= {mr[63:3], 3'b000};
                  wdata_q <= is_store ? wdata_d : '0;
                  wstrb_q <= is_store ? wstrb_d : '0;
                  off_q   <= mr[2:0];
                  func3_q <= mfunc3;
                  cnt_q   <= '0;
                  state_q <= S_WAIT;
               end
            end
            S_WAIT: begin
               mfault_q <= 1'b0;
               cnt_q    <= cnt_q + 8'd1;
               if (dmem_ack) begin
                  req_q   <= 1'b0;
                  we_q    <= 1'b0;
                  wstrb_q <= '0;
                  if (!store_q) mdata_q <= ldata_d;
                  mdone_q <= 1'b1;
                  state_q <= S_DONE;
               end else if (cnt_q == TMO_LAST) begin
                  req_q     <= 1'b0;
                  we_q      <= 1'b0;
                  wstrb_q   <= '0;
                  mbuserr_q <= 1'b1;
                  mdata_q   <= '0;
                  state_q   <= S_DONE;
               end
            end
            S_DONE: begin
               mdone_q   <= 1'b0;
               mbuserr_q <= 1'b0;
               mfault_q  <= 1'b0;
               cnt_q     <= '0;
               state_q   <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign dmem_req   = req_q;
   assign dmem_we    = we_q;
   assign dmem_addr  = addr_q;
   assign dmem_wdata = wdata_q;
   assign dmem_wstrb = wstrb_q;
   assign mdata      = mdata_q;
   assign mdone      = mdone_q;
   assign mfault     = mfault_q;
   assign mbuserr    = mbuserr_q;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Bench for dmem_access_ctrl: directed test-plan steps plus randomized accesses
// checked against a byte-level reference model.
module tb_dmem_access_ctrl;

   localparam int unsigned TMO = 4;

   logic        clk = 1'b0;
   logic        resetn;
   logic        mwmem, mm2reg;
   logic [2:0]  mfunc3;
   logic [63:0] mr, mqb;
   logic        dmem_req, dmem_we;
   logic [63:0] dmem_addr, dmem_wdata;
   logic [7:0]  dmem_wstrb;
   logic        dmem_ack;
   logic [63:0] dmem_rdata;
   logic        mem_stall;
   logic [63:0] mdata;
   logic        mdone, mfault, mbuserr;

   int unsigned n_tests = 0;
   int unsigned n_fail  = 0;
   logic [63:0] exp_mdata;

   dmem_access_ctrl #(.TIMEOUT_CYCLES(TMO)) dut (
      .clk(clk), .resetn(resetn), .mwmem(mwmem), .mm2reg(mm2reg), .mfunc3(mfunc3),
      .mr(mr), .mqb(mqb), .dmem_req(dmem_req), .dmem_we(dmem_we),
      .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb),
      .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata), .mem_stall(mem_stall),
      .mdata(mdata), .mdone(mdone), .mfault(mfault), .mbuserr(mbuserr)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got no_finish required finish");
      $fatal(1, "bench timed out");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: got 0x%0h required 0x%0h", tag, obs, exp);
      end
   endtask

   // Gather the accessed bytes, then extend from the top accessed byte.
   function automatic logic [63:0] ref_load(input logic [2:0] f3, input logic [2:0] off,
                                            input logic [63:0] rd);
      int unsigned n;
      logic [63:0] r;
      n = 1 << f3[1:0];
      r = '0;
      for (int unsigned b = 0; b < n; b++) r[8*b +: 8] = rd[8*(off+b) +: 8];
      if (!f3[2] && n < 8 && r[8*n-1])
         for (int unsigned b = n; b < 8; b++) r[8*b +: 8] = 8'hFF;
      return r;
   endfunction

   task automatic do_access(input logic st, input logic ld, input logic [2:0] f3,
                            input logic [63:0] addr, input logic [63:0] data,
                            input int unsigned ack_lat, input logic [63:0] rd);
      int unsigned n;
      logic        legal, acked;
      logic [7:0]  strb;
      n = 1 << f3[1:0];
      legal = st ? (f3 <= 3'd2) : (f3 != 3'd7);
      if ((addr % n) != 0) legal = 1'b0;
      strb = '0;
      if (legal) for (int unsigned b = 0; b < n; b++) strb[addr[2:0] + b] = 1'b1;
      mwmem = st; mm2reg = ld; mfunc3 = f3; mr = addr; mqb = data;
      #1;
      if (!st && !ld) begin
         check("idle_stall", mem_stall, 0);
         @(negedge clk);
         check("idle_req", dmem_req, 0);
         check("idle_fault", mfault, 0);
         check("idle_done", mdone, 0);
         return;
      end
      check("start_stall", mem_stall, legal);
      check("start_req", dmem_req, 0);
      @(negedge clk);
      if (!legal) begin
         check("fault_pulse", mfault, 1);
         check("fault_req", dmem_req, 0);
         check("fault_stall", mem_stall, 0);
         check("fault_done", mdone, 0);
         mwmem = 0; mm2reg = 0;
         @(negedge clk);
         check("fault_clear", mfault, 0);
         check("fault_req2", dmem_req, 0);
         return;
      end
      check("req_hi", dmem_req, 1);
      check("we", dmem_we, st);
      check("addr", dmem_addr, {addr[63:3], 3'b000});
      check("wstrb", dmem_wstrb, st ? strb : 8'h00);
      check("wdata", dmem_wdata, st ? (data << (8 * addr[2:0])) : 64'd0);
      acked = 1'b0;
      for (int unsigned i = 0; i < TMO; i++) begin
         acked = (i == ack_lat);
         dmem_ack = acked;
         dmem_rdata = acked ? rd : {$urandom, $urandom};
         #1;
         check("wait_req", dmem_req, 1);
         check("wait_stall", mem_stall, 1);
         if (acked || i == TMO - 1) break;
         @(negedge clk);
      end
      @(negedge clk);
      dmem_ack = 0;
      if (acked && !st) exp_mdata = ref_load(f3, addr[2:0], rd);
      else if (!acked) exp_mdata = '0;
      #1;
      check("done_pulse", mdone, acked);
      check("buserr_pulse", mbuserr, !acked);
      check("mdata", mdata, exp_mdata);
      check("done_req", dmem_req, 0);
      check("done_wstrb", dmem_wstrb, 0);
      check("done_stall", mem_stall, 0);
      mwmem = 0; mm2reg = 0;
      @(negedge clk);
      check("post_done", mdone, 0);
      check("post_buserr", mbuserr, 0);
      check("post_req", dmem_req, 0);
   endtask

   initial begin
      int unsigned kind, lat;
      logic [2:0]  f3;
      logic [63:0] a;

      resetn = 0; mwmem = 1; mm2reg = 0; mfunc3 = 3'b000; mr = 64'h10;
      mqb = '0; dmem_ack = 0; dmem_rdata = '0; exp_mdata = '0;
      #1;
      check("rst_stall", mem_stall, 0);
      check("rst_req", dmem_req, 0);
      check("rst_mdata", mdata, 0);
      check("rst_pulses", {mdone, mfault, mbuserr}, 0);
      check("rst_wstrb", dmem_wstrb, 0);
      mwmem = 0;
      @(negedge clk);
      resetn = 1;
      @(negedge clk);

      do_access(0, 1, 3'b011, 64'h1000, 0, 0, 64'h1122334455667788);
      do_access(0, 1, 3'b000, 64'h1003, 0, 1, 64'h0000000080000000);
      do_access(0, 1, 3'b100, 64'h1003, 0, 2, 64'h0000000080000000);
      do_access(1, 0, 3'b001, 64'h2006, 64'hABCD, 0, 0);
      do_access(0, 1, 3'b010, 64'h3002, 0, 0, 0);
      do_access(1, 0, 3'b010, 64'h5004, 64'hDEADBEEF, TMO + 5, 0);
      do_access(0, 1, 3'b010, 64'h5004, 0, TMO - 1, 64'h8765432100000000);
      do_access(1, 0, 3'b011, 64'h6000, 64'h1, 0, 0);
      do_access(1, 0, 3'b100, 64'h6000, 64'h1, 0, 0);
      do_access(0, 1, 3'b111, 64'h6000, 0, 0, 0);

      // ack outside WAIT must be ignored
      dmem_ack = 1; dmem_rdata = 64'hFFFF;
      @(negedge clk);
      check("stray_ack_done", mdone, 0);
      check("stray_ack_req", dmem_req, 0);
      check("stray_ack_mdata", mdata, exp_mdata);
      dmem_ack = 0;

      // reset mid-WAIT
      mm2reg = 1; mfunc3 = 3'b011; mr = 64'h4000;
      @(negedge clk);
      check("rstw_req", dmem_req, 1);
      @(negedge clk);
      resetn = 0;
      #1;
      check("rstw_req_drop", dmem_req, 0);
      check("rstw_stall", mem_stall, 0);
      check("rstw_done", mdone, 0);
      exp_mdata = '0;
      @(negedge clk);
      resetn = 1;
      do_access(1, 1, 3'b010, 64'h4008, 64'h0BADF00D, 1, 64'h77);

      for (int unsigned t = 0; t < 60; t++) begin
         kind = $urandom_range(0, 7);
         f3 = 3'($urandom_range(0, 7));
         a = {$urandom, $urandom};
         if ($urandom_range(0, 3) != 0) a = a & ~((64'd1 << f3[1:0]) - 1);
         lat = $urandom_range(0, TMO);
         do_access(kind == 7 || (kind >= 1 && kind <= 3), kind >= 4,
                   f3, a, {$urandom, $urandom}, lat, {$urandom, $urandom});
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/dmem_access_ctrl.md
Name: dmem_access_ctrl

Overview:
Sequences data-memory accesses for the instruction held in the EXE/MEM pipeline register of the RV64 pipeline. It drives a req/ack data-memory bus, formats store data and strobes, and aligns and extends load data for the MEM/WB register. It also raises a stall that freezes PC, IF/ID, ID/EXE and EXE/MEM until the access completes, and flags misaligned or illegal accesses and bus timeouts.

Parameters:
TIMEOUT_CYCLES, 255, number of WAIT cycles without ack before the access is aborted (1..255).

Ports:
clk  in  1  rising-edge clock
resetn  in  1  asynchronous active-low reset
mwmem  in  1  store request from the EXE/MEM register
mm2reg  in  1  load request from the EXE/MEM register
mfunc3  in  3  access size/sign: 000 B, 001 H, 010 W, 011 D, 100 BU, 101 HU, 110 WU, 111 illegal
mr  in  64  effective byte address
mqb  in  64  store data (rs2), right-aligned
dmem_req  out  1  bus request, registered
dmem_we  out  1  1 = write, registered
dmem_addr  out  64  doubleword-aligned address ({mr[63:3],3'b0}), registered
dmem_wdata  out  64  store data shifted to byte lane, registered
dmem_wstrb  out  8  byte strobes, registered; 0 for reads
dmem_ack  in  1  bus completion; may be asserted in the first cycle dmem_req is high
dmem_rdata  in  64  read doubleword, valid when dmem_ack=1
mem_stall  out  1  combinational pipeline freeze
mdata  out  64  formatted load result, registered
mdone  out  1  one-cycle pulse: access complete, mdata valid
mfault  out  1  one-cycle pulse: misaligned or illegal-func3 access, no bus cycle
mbuserr  out  1  one-cycle pulse: access aborted by timeout

Behaviour:
- Reset (resetn=0, async): state IDLE; dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb, mdata, mdone, mfault, mbuserr all 0; timeout counter 0. mem_stall is forced to 0 while resetn=0.
- Access = mwmem | mm2reg. If both are set, the access is a store and the load is ignored.
- Size from mfunc3[1:0]: 1, 2, 4 or 8 bytes. mfunc3=111, or 011 with mwmem, is illegal. Stores use only mfunc3[1:0]; mfunc3[2] must be 0 for stores, else the access is illegal.
- Misaligned when mr[2:0] is not a multiple of the size.
- State IDLE:
  - access and legal: mem_stall=1. At the edge, latch bus outputs, dmem_req<=1, go to WAIT.
  - access and faulty: mem_stall=0, mfault<=1 for one cycle; no bus activity; stay in IDLE.
  - no access: outputs idle, mem_stall=0.
- Store formatting: dmem_wstrb = ((1<<size)-1) << mr[2:0]; dmem_wdata = mqb << (8*mr[2:0]).
- State WAIT: mem_stall=1; counter increments each cycle.
  - dmem_ack=1: dmem_req<=0, dmem_we<=0, dmem_wstrb<=0. For loads, mdata <= extend(dmem_rdata >> 8*mr[2:0]): sign-extend for 000/001/010, zero-extend for 100/101/110, none for 011. For stores, mdata is unchanged. mdone<=1. Go to DONE.
  - Counter reaches TIMEOUT_CYCLES with no ack: dmem_req<=0, mbuserr<=1, mdata<=0. Go to DONE; mdone is not asserted.
  - dmem_ack and timeout in the same cycle: ack wins.
- State DONE: mem_stall=0, so the pipeline advances at the end of this cycle. Pulses clear, counter clears, go to IDLE.
- DONE always returns to IDLE. Back-to-back accesses cost a minimum of 3 cycles each in the MEM stage: IDLE, WAIT, DONE.
- dmem_ack while not in WAIT is ignored.
- mr, mqb, mfunc3 and the request flags must be held stable by the stalled EXE/MEM register throughout WAIT. The block uses its latched copies on the bus.
- Reset asserted mid-WAIT drops dmem_req immediately with no mdone. The memory must tolerate an abandoned request.

Test Plan:
- Load LD, mr=0x1000, ack one cycle after req, rdata=0x1122334455667788 -> dmem_addr=0x1000, wstrb=0, stall high 2 cycles, mdone pulse, mdata=0x1122334455667788.
- Load LB, mr=0x1003, rdata=0x00000000_80000000 -> byte 0x80, mdata=0xFFFFFFFFFFFFFF80; same with LBU -> 0x80.
- Store SH, mr=0x2006, mqb=0xABCD -> dmem_addr=0x2000, wstrb=0xC0, wdata=0xABCD000000000000, we=1.
- Misaligned LW at mr=0x3002 -> mfault single pulse, dmem_req never high, mem_stall=0.
- TIMEOUT_CYCLES=4, store with ack never asserted -> req high exactly 4 cycles, mbuserr pulse, no mdone, stall released in DONE.
- Async reset (resetn low mid-WAIT), then mwmem=mm2reg=1 after reset -> req drops at once; next access is performed as a store.
